// File: rtl/mux41_rr_ctrl.sv
// Round-robin 4:1 select path: arbitrates four requesters and presents the owner's word under valid/ready.
// Optional per-grant transfer limit with preemption is enabled by defining MUXARB_HOLD_LIMIT_EN.
module mux41_rr_ctrl #(
  parameter int W        = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] d,
  input  logic           ready,
  output logic [3:0]     gnt,
  output logic [1:0]     s,
  output logic [W-1:0]   y,
  output logic           y_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [2:0] pick_all_s;
  logic [2:0] pick_oth_s;

  // Returns {found, index}: scans base+1, base+2, base+3 and, if incl_base, base itself last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base,
                                         input logic incl_base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = base;
    for (int i = 1; i < 4; i++) begin
      cand = base + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    if (!found && incl_base && r[base]) begin
      found = 1'b1;
      idx   = base;
    end else begin
      found = found;
    end
    return {found, idx};
  endfunction

  assign pick_all_s = rr_pick(req, ptr_q, 1'b1);
  assign pick_oth_s = rr_pick(req, s_q, 1'b0);

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign y       = d[int'(s_q)*W +: W];
  assign y_valid = (state_q == GRANT) && req[s_q];

`ifdef MUXARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [7:0] count_q, count_d;
  logic [7:0] cnt_inc_s;
  logic       xfer_s;

  assign xfer_s    = y_valid && ready;
  assign cnt_inc_s = (xfer_s && (count_q < HOLD_LIM)) ? (count_q + 8'd1) : count_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ready ^ (HOLD_MAX > 0);
`endif

  // Next-state: grant from idle, handover on release, optional preemption at the hold limit.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
`ifdef MUXARB_HOLD_LIMIT_EN
    count_d = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_all_s[2]) begin
          state_d = GRANT;
          s_d     = pick_all_s[1:0];
          ptr_d   = pick_all_s[1:0];
          gnt_d   = 4'b0001 << pick_all_s[1:0];
`ifdef MUXARB_HOLD_LIMIT_EN
          count_d = 8'd0;
`endif
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        if (!req[s_q]) begin
          // Release wins over preemption; hand over directly when someone else is waiting.
          if (pick_oth_s[2]) begin
            s_d   = pick_oth_s[1:0];
            ptr_d = pick_oth_s[1:0];
            gnt_d = 4'b0001 << pick_oth_s[1:0];
`ifdef MUXARB_HOLD_LIMIT_EN
            count_d = 8'd0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
`ifdef MUXARB_HOLD_LIMIT_EN
          if (cnt_inc_s >= HOLD_LIM) begin
            count_d = 8'd0;
            if (pick_oth_s[2]) begin
              s_d   = pick_oth_s[1:0];
              ptr_d = pick_oth_s[1:0];
              gnt_d = 4'b0001 << pick_oth_s[1:0];
            end else begin
              gnt_d = gnt_q;
            end
          end else begin
            count_d = cnt_inc_s;
          end
`else
          gnt_d = gnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 2'b00;
      ptr_q   <= 2'b11;
      gnt_q   <= 4'b0000;
`ifdef MUXARB_HOLD_LIMIT_EN
      count_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
`ifdef MUXARB_HOLD_LIMIT_EN
      count_q <= count_d;
`endif
    end
  end

endmodule
